tdm_demux2: RTL

Receive end of the team's two-channel time-division link. It consumes a word stream in which channel-0 and channel-1 samples alternate, with a frame marker on each channel-0 word. It rebuilds the two channel values on registered outputs and pulses a valid strobe per complete frame. It also reports lock and sticky framing errors, and counts frames. It sits after the 2:1 selection stage that interleaves the channels.

---
 rtl/tdm_demux2_pkg.sv | 13 +
 rtl/tdm_demux2_frame_counter.sv | 19 +
 rtl/tdm_demux2.sv | 119 +++++++++++
 3 files changed

// File: rtl/tdm_demux2_pkg.sv
// Shared definitions for the two-channel TDM link: state encoding and default sample width.
// The transmit-side interleaver imports this too, so both ends agree on the marker convention.
package tdm_demux2_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP1 = 2'd1,
    EXP0 = 2'd2
  } tdm_state_t;

endpackage

// File: rtl/tdm_demux2_frame_counter.sv
// Free-running count of completed frames; wraps silently at 2^CNT_W.
module tdm_demux2_frame_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Receive end of the two-channel TDM link: realigns on channel-0 markers, rebuilds
// both channel samples per frame, and reports lock, sticky framing errors and a frame count.
module tdm_demux2
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             V,
  input  logic             F,
  input  logic             CLR,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic             VLD,
  output logic             LOCK,
  output logic             ERR,
  output logic [CNT_W-1:0] FCNT
);

  tdm_state_t       state;
  tdm_state_t       state_next;
  logic [WIDTH-1:0] hold;
  logic             hold_load;
  logic             frame_done;
  logic             err_set;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // A marker always reloads hold, even in EXP1, so a missing channel-1 word resyncs on the new frame.
  always_comb begin
    state_next = state;
    hold_load  = 1'b0;
    frame_done = 1'b0;
    err_set    = 1'b0;
    case (state)
      HUNT: begin
        if (V && F) begin
          hold_load  = 1'b1;
          state_next = EXP1;
        end
      end
      EXP1: begin
        if (V) begin
          if (F) begin
            err_set   = 1'b1;
            hold_load = 1'b1;
          end else begin
            frame_done = 1'b1;
            state_next = EXP0;
          end
        end
      end
      EXP0: begin
        if (V) begin
          if (F) begin
            hold_load  = 1'b1;
            state_next = EXP1;
          end else begin
            err_set    = 1'b1;
            state_next = HUNT;
          end
        end
      end
      default: begin
        state_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold <= '0;
      Y0   <= '0;
      Y1   <= '0;
      VLD  <= 1'b0;
      LOCK <= 1'b0;
    end else begin
      if (hold_load) begin
        hold <= D;
      end
      if (frame_done) begin
        Y0 <= hold;
        Y1 <= D;
      end
      VLD  <= frame_done;
      LOCK <= (state_next != HUNT);
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (err_set) begin
      ERR <= 1'b1;
    end else if (CLR) begin
      ERR <= 1'b0;
    end
  end

  tdm_demux2_frame_counter #(
    .CNT_W(CNT_W)
  ) u_frame_counter (
    .CLK  (CLK),
    .RST  (RST),
    .en   (frame_done),
    .count(FCNT)
  );

endmodule
